// File: rtl/wb_stage_pipe_if.sv
// Purpose: handshake/bus bundle for the write-back pipeline register chain.
// Signals:
//   stall, flush            pipeline control from hazard unit
//   in_*                    memory-stage slot entering the chain
//   out_*                   oldest stage, towards the register-file write port
//   q0_*/q1_*               forwarding query address and result
// Modports: master = memory stage / query side, slave = wb_stage_pipe.
interface wb_stage_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_instr;
  logic [DATA_W-1:0] in_pc;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_addr;
  logic              in_we;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_we;
  logic [ADDR_W-1:0] q0_addr;
  logic [ADDR_W-1:0] q1_addr;
  logic              q0_hit;
  logic              q1_hit;
  logic [DATA_W-1:0] q0_data;
  logic [DATA_W-1:0] q1_data;

  modport master (
    output stall, flush, in_valid, in_instr, in_pc, in_data, in_addr, in_we,
    output q0_addr, q1_addr,
    input  out_valid, out_instr, out_pc, out_data, out_addr, out_we,
    input  q0_hit, q1_hit, q0_data, q1_data
  );

  modport slave (
    input  stall, flush, in_valid, in_instr, in_pc, in_data, in_addr, in_we,
    input  q0_addr, q1_addr,
    output out_valid, out_instr, out_pc, out_data, out_addr, out_we,
    output q0_hit, q1_hit, q0_data, q1_data
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// Purpose: DEPTH-stage write-back register chain (MEM -> register file) with
// stall, flush, per-stage valid, and two forwarding query ports that return
// the youngest pending write to a requested register.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, clears every stage
//   bus    wb_stage_pipe_if.slave (stall/flush, in_*, out_*, q0_*/q1_*)
// Configuration macro: WB_FWD_EN -- when defined the forwarding search is
// built; otherwise q*_hit/q*_data are tied to zero.
module wb_stage_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 1
) (
  input logic             clk,
  input logic             reset,
  wb_stage_pipe_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              we;
  } stageT;

  // Index 0 is stage 1 (youngest), index DEPTH-1 drives out_*.
  stageT [DEPTH-1:0] stages;
  stageT [DEPTH-1:0] stagesNext;
  stageT             inEntry;
  stageT             lastStage;

  assign inEntry = '{valid: bus.in_valid, instr: bus.in_instr, pc: bus.in_pc,
                     data: bus.in_data, addr: bus.in_addr, we: bus.in_we};

  // Next-state: flush beats stall; stall holds; otherwise shift by one.
  always_comb begin
    stagesNext = stages;
    if (bus.flush) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        stagesNext[k].valid = 1'b0;
        stagesNext[k].we    = 1'b0;
      end
    end else if (!bus.stall) begin
      stagesNext[0] = inEntry;
      for (int k = 1; k < int'(DEPTH); k++) begin
        stagesNext[k] = stages[k-1];
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stages <= '0;
    end else begin
      stages <= stagesNext;
    end
  end

  assign lastStage     = stages[DEPTH-1];
  assign bus.out_valid = lastStage.valid;
  assign bus.out_instr = lastStage.instr;
  assign bus.out_pc    = lastStage.pc;
  assign bus.out_data  = lastStage.data;
  assign bus.out_addr  = lastStage.addr;
  // $0 is hard-wired zero, so writes to it never leave the pipe.
  assign bus.out_we    = lastStage.valid & lastStage.we &
                         (lastStage.addr != ADDR_W'(0));

`ifdef WB_FWD_EN
  // Returns {hit, data}; scanning oldest to youngest lets the youngest win.
  function automatic logic [DATA_W:0] fwdLookup(
    input logic [ADDR_W-1:0] qAddr,
    input stageT [DEPTH-1:0] st
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (st[k].valid && st[k].we && (st[k].addr == qAddr) &&
          (st[k].addr != ADDR_W'(0))) begin
        res = {1'b1, st[k].data};
      end
    end
    return res;
  endfunction

  logic [DATA_W:0] q0Res;
  logic [DATA_W:0] q1Res;

  always_comb begin
    q0Res = fwdLookup(bus.q0_addr, stages);
    q1Res = fwdLookup(bus.q1_addr, stages);
  end

  assign bus.q0_hit  = q0Res[DATA_W];
  assign bus.q0_data = q0Res[DATA_W-1:0];
  assign bus.q1_hit  = q1Res[DATA_W];
  assign bus.q1_data = q1Res[DATA_W-1:0];
`else
  // Query ports kept for a uniform footprint; addresses are deliberately ignored.
  logic unusedQueryAddr;
  assign unusedQueryAddr = ^{bus.q0_addr, bus.q1_addr};

  assign bus.q0_hit  = 1'b0;
  assign bus.q0_data = DATA_W'(0);
  assign bus.q1_hit  = 1'b0;
  assign bus.q1_data = DATA_W'(0);
`endif

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Purpose: directed self-checking bench for wb_stage_pipe at DEPTH 1, 2 and 3.
// Expected forwarding results follow WB_FWD_EN as seen by this compilation.
module tb_wb_stage_pipe;

`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wb_stage_pipe_if #(.DATA_W(32), .ADDR_W(5)) if1 ();
  wb_stage_pipe_if #(.DATA_W(32), .ADDR_W(5)) if2 ();
  wb_stage_pipe_if #(.DATA_W(32), .ADDR_W(5)) if3 ();

  wb_stage_pipe #(.DATA_W(32), .ADDR_W(5), .DEPTH(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
  wb_stage_pipe #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) u2 (.clk(clk), .reset(reset), .bus(if2));
  wb_stage_pipe #(.DATA_W(32), .ADDR_W(5), .DEPTH(3)) u3 (.clk(clk), .reset(reset), .bus(if3));

  task automatic drv1(input logic v, input logic we, input logic [4:0] a,
                      input logic [31:0] d, input logic [31:0] pc);
    if1.in_valid = v; if1.in_we = we; if1.in_addr = a; if1.in_data = d;
    if1.in_pc = pc; if1.in_instr = {16'hC0DE, d[15:0]};
  endtask

  task automatic drv2(input logic v, input logic we, input logic [4:0] a,
                      input logic [31:0] d, input logic [31:0] pc);
    if2.in_valid = v; if2.in_we = we; if2.in_addr = a; if2.in_data = d;
    if2.in_pc = pc; if2.in_instr = {16'hC0DE, d[15:0]};
  endtask

  task automatic drv3(input logic v, input logic we, input logic [4:0] a,
                      input logic [31:0] d, input logic [31:0] pc);
    if3.in_valid = v; if3.in_we = we; if3.in_addr = a; if3.in_data = d;
    if3.in_pc = pc; if3.in_instr = {16'hC0DE, d[15:0]};
  endtask

  task automatic idleAll();
    drv1(0, 0, 0, 0, 0); drv2(0, 0, 0, 0, 0); drv3(0, 0, 0, 0, 0);
    if1.stall = 0; if1.flush = 0; if1.q0_addr = 0; if1.q1_addr = 0;
    if2.stall = 0; if2.flush = 0; if2.q0_addr = 0; if2.q1_addr = 0;
    if3.stall = 0; if3.flush = 0; if3.q0_addr = 0; if3.q1_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    idleAll();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idleAll();
    reset = 1'b1;
    tick();
    checks++; if (if1.out_valid !== 1'b0) begin failures++; $display("FAIL rst_d1_valid got=%0h exp=0", if1.out_valid); end
    checks++; if (if2.out_valid !== 1'b0) begin failures++; $display("FAIL rst_d2_valid got=%0h exp=0", if2.out_valid); end
    checks++; if (if3.out_we !== 1'b0) begin failures++; $display("FAIL rst_d3_we got=%0h exp=0", if3.out_we); end
    checks++; if (if3.out_data !== 32'h0) begin failures++; $display("FAIL rst_d3_data got=%0h exp=0", if3.out_data); end
    checks++; if (if3.out_pc !== 32'h0) begin failures++; $display("FAIL rst_d3_pc got=%0h exp=0", if3.out_pc); end
    checks++; if (if3.out_instr !== 32'h0) begin failures++; $display("FAIL rst_d3_instr got=%0h exp=0", if3.out_instr); end
    checks++; if (if3.out_addr !== 5'h0) begin failures++; $display("FAIL rst_d3_addr got=%0h exp=0", if3.out_addr); end
    checks++; if (if3.q0_hit !== 1'b0 || if3.q0_data !== 32'h0) begin failures++; $display("FAIL rst_d3_q0 got=%0h/%0h exp=0/0", if3.q0_hit, if3.q0_data); end
    reset = 1'b0;
  endtask

  task automatic test_latency();
    applyReset();
    drv3(1, 1, 5'd8, 32'h1234, 32'h3000);
    if3.q0_addr = 5'd8;
    tick();
    drv3(0, 0, 0, 0, 0);
    #1;
    checks++; if (if3.out_valid !== 1'b0) begin failures++; $display("FAIL lat_e0_valid got=%0h exp=0", if3.out_valid); end
    checks++; if (if3.q0_hit !== FWD) begin failures++; $display("FAIL lat_e0_q0hit got=%0h exp=%0h", if3.q0_hit, FWD); end
    checks++; if (if3.q0_data !== (FWD ? 32'h1234 : 32'h0)) begin failures++; $display("FAIL lat_e0_q0data got=%0h exp=%0h", if3.q0_data, (FWD ? 32'h1234 : 32'h0)); end
    tick();
    checks++; if (if3.out_valid !== 1'b0 || if3.out_we !== 1'b0) begin failures++; $display("FAIL lat_e1 got=%0h/%0h exp=0/0", if3.out_valid, if3.out_we); end
    tick();
    checks++; if (if3.out_valid !== 1'b1) begin failures++; $display("FAIL lat_e2_valid got=%0h exp=1", if3.out_valid); end
    checks++; if (if3.out_addr !== 5'd8) begin failures++; $display("FAIL lat_e2_addr got=%0h exp=8", if3.out_addr); end
    checks++; if (if3.out_data !== 32'h1234) begin failures++; $display("FAIL lat_e2_data got=%0h exp=1234", if3.out_data); end
    checks++; if (if3.out_pc !== 32'h3000) begin failures++; $display("FAIL lat_e2_pc got=%0h exp=3000", if3.out_pc); end
    checks++; if (if3.out_instr !== 32'hC0DE1234) begin failures++; $display("FAIL lat_e2_instr got=%0h exp=c0de1234", if3.out_instr); end
    checks++; if (if3.out_we !== 1'b1) begin failures++; $display("FAIL lat_e2_we got=%0h exp=1", if3.out_we); end
    tick();
    checks++; if (if3.out_valid !== 1'b0 || if3.out_we !== 1'b0) begin failures++; $display("FAIL lat_e3 got=%0h/%0h exp=0/0", if3.out_valid, if3.out_we); end
  endtask

  task automatic test_zero_suppress();
    applyReset();
    drv1(1, 1, 5'd0, 32'hFFFF, 32'h100);
    if1.q0_addr = 5'd0;
    tick();
    checks++; if (if1.out_valid !== 1'b1) begin failures++; $display("FAIL z0_valid got=%0h exp=1", if1.out_valid); end
    checks++; if (if1.out_we !== 1'b0) begin failures++; $display("FAIL z0_we got=%0h exp=0", if1.out_we); end
    checks++; if (if1.out_data !== 32'hFFFF) begin failures++; $display("FAIL z0_data got=%0h exp=ffff", if1.out_data); end
    checks++; if (if1.q0_hit !== 1'b0 || if1.q0_data !== 32'h0) begin failures++; $display("FAIL z0_q0 got=%0h/%0h exp=0/0", if1.q0_hit, if1.q0_data); end
    drv1(1, 1, 5'd3, 32'h33, 32'h104);
    if1.q0_addr = 5'd3;
    if1.q1_addr = 5'd4;
    tick();
    checks++; if (if1.out_we !== 1'b1 || if1.out_addr !== 5'd3) begin failures++; $display("FAIL z3_we got=%0h/%0h exp=1/3", if1.out_we, if1.out_addr); end
    checks++; if (if1.q0_hit !== FWD || if1.q0_data !== (FWD ? 32'h33 : 32'h0)) begin failures++; $display("FAIL z3_q0 got=%0h/%0h exp=%0h/%0h", if1.q0_hit, if1.q0_data, FWD, (FWD ? 32'h33 : 32'h0)); end
    checks++; if (if1.q1_hit !== 1'b0 || if1.q1_data !== 32'h0) begin failures++; $display("FAIL z3_q1miss got=%0h/%0h exp=0/0", if1.q1_hit, if1.q1_data); end
    drv1(1, 0, 5'd3, 32'h44, 32'h108);
    tick();
    checks++; if (if1.out_valid !== 1'b1 || if1.out_we !== 1'b0) begin failures++; $display("FAIL zwe0 got=%0h/%0h exp=1/0", if1.out_valid, if1.out_we); end
    checks++; if (if1.q0_hit !== 1'b0) begin failures++; $display("FAIL zwe0_q0 got=%0h exp=0", if1.q0_hit); end
    drv1(0, 0, 0, 0, 0);
  endtask

  task automatic test_stall_flush();
    applyReset();
    drv2(1, 1, 5'd1, 32'h11, 32'h200);
    tick();
    drv2(1, 1, 5'd2, 32'h22, 32'h204);
    tick();
    checks++; if (if2.out_addr !== 5'd1 || if2.out_data !== 32'h11 || if2.out_we !== 1'b1) begin failures++; $display("FAIL sf_pre got=%0h/%0h/%0h exp=1/11/1", if2.out_addr, if2.out_data, if2.out_we); end
    if2.stall = 1'b1;
    drv2(1, 1, 5'd3, 32'h33, 32'h208);
    if2.q0_addr = 5'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (if2.out_valid !== 1'b1 || if2.out_addr !== 5'd1 || if2.out_data !== 32'h11) begin failures++; $display("FAIL sf_stall%0d got=%0h/%0h/%0h exp=1/1/11", i, if2.out_valid, if2.out_addr, if2.out_data); end
    end
    checks++; if (if2.q0_hit !== FWD || if2.q0_data !== (FWD ? 32'h22 : 32'h0)) begin failures++; $display("FAIL sf_stall_q0 got=%0h/%0h exp=%0h/%0h", if2.q0_hit, if2.q0_data, FWD, (FWD ? 32'h22 : 32'h0)); end
    if2.stall = 1'b0;
    tick();
    checks++; if (if2.out_valid !== 1'b1 || if2.out_addr !== 5'd2 || if2.out_data !== 32'h22) begin failures++; $display("FAIL sf_release got=%0h/%0h/%0h exp=1/2/22", if2.out_valid, if2.out_addr, if2.out_data); end
    if2.stall = 1'b1;
    if2.flush = 1'b1;
    drv2(1, 1, 5'd4, 32'h44, 32'h20C);
    if2.q0_addr = 5'd3;
    tick();
    checks++; if (if2.out_valid !== 1'b0 || if2.out_we !== 1'b0) begin failures++; $display("FAIL sf_flush got=%0h/%0h exp=0/0", if2.out_valid, if2.out_we); end
    checks++; if (if2.q0_hit !== 1'b0 || if2.q0_data !== 32'h0) begin failures++; $display("FAIL sf_flush_q0 got=%0h/%0h exp=0/0", if2.q0_hit, if2.q0_data); end
    if2.stall = 1'b0;
    if2.flush = 1'b0;
    drv2(0, 0, 0, 0, 0);
    tick();
    checks++; if (if2.out_valid !== 1'b0) begin failures++; $display("FAIL sf_post1 got=%0h exp=0", if2.out_valid); end
    tick();
    checks++; if (if2.out_valid !== 1'b0) begin failures++; $display("FAIL sf_post2 got=%0h exp=0", if2.out_valid); end
  endtask

  task automatic test_reset_midstream();
    applyReset();
    drv2(1, 1, 5'd6, 32'h66, 32'h300);
    tick();
    drv2(1, 1, 5'd7, 32'h77, 32'h304);
    tick();
    drv2(0, 0, 0, 0, 0);
    if2.q0_addr = 5'd7;
    #1;
    checks++; if (if2.out_valid !== 1'b1 || if2.out_addr !== 5'd6) begin failures++; $display("FAIL rm_pre got=%0h/%0h exp=1/6", if2.out_valid, if2.out_addr); end
    checks++; if (if2.q0_hit !== FWD) begin failures++; $display("FAIL rm_pre_q0 got=%0h exp=%0h", if2.q0_hit, FWD); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (if2.out_valid !== 1'b0 || if2.out_we !== 1'b0) begin failures++; $display("FAIL rm_async got=%0h/%0h exp=0/0", if2.out_valid, if2.out_we); end
    checks++; if (if2.out_data !== 32'h0 || if2.out_addr !== 5'h0 || if2.out_pc !== 32'h0 || if2.out_instr !== 32'h0) begin failures++; $display("FAIL rm_fields got=%0h/%0h/%0h/%0h exp=0/0/0/0", if2.out_data, if2.out_addr, if2.out_pc, if2.out_instr); end
    checks++; if (if2.q0_hit !== 1'b0 || if2.q0_data !== 32'h0) begin failures++; $display("FAIL rm_q0 got=%0h/%0h exp=0/0", if2.q0_hit, if2.q0_data); end
    reset = 1'b0;
    tick();
    checks++; if (if2.out_valid !== 1'b0 || if2.out_data !== 32'h0) begin failures++; $display("FAIL rm_after got=%0h/%0h exp=0/0", if2.out_valid, if2.out_data); end
    drv2(1, 1, 5'd9, 32'h99, 32'h308);
    tick();
    drv2(0, 0, 0, 0, 0);
    tick();
    checks++; if (if2.out_valid !== 1'b1 || if2.out_addr !== 5'd9 || if2.out_data !== 32'h99) begin failures++; $display("FAIL rm_new got=%0h/%0h/%0h exp=1/9/99", if2.out_valid, if2.out_addr, if2.out_data); end
  endtask

  task automatic test_forward_priority();
    applyReset();
    drv3(1, 1, 5'd5, 32'hA, 32'h400);
    tick();
    drv3(1, 0, 5'd5, 32'hD, 32'h404);
    tick();
    drv3(1, 1, 5'd5, 32'hB, 32'h408);
    tick();
    drv3(0, 0, 0, 0, 0);
    if3.q0_addr = 5'd5;
    if3.q1_addr = 5'd5;
    #1;
    checks++; if (if3.q0_hit !== FWD || if3.q0_data !== (FWD ? 32'hB : 32'h0)) begin failures++; $display("FAIL fp_young_q0 got=%0h/%0h exp=%0h/%0h", if3.q0_hit, if3.q0_data, FWD, (FWD ? 32'hB : 32'h0)); end
    checks++; if (if3.q1_hit !== FWD || if3.q1_data !== (FWD ? 32'hB : 32'h0)) begin failures++; $display("FAIL fp_young_q1 got=%0h/%0h exp=%0h/%0h", if3.q1_hit, if3.q1_data, FWD, (FWD ? 32'hB : 32'h0)); end
    checks++; if (if3.out_addr !== 5'd5 || if3.out_data !== 32'hA || if3.out_we !== 1'b1) begin failures++; $display("FAIL fp_out got=%0h/%0h/%0h exp=5/a/1", if3.out_addr, if3.out_data, if3.out_we); end
    if3.q1_addr = 5'd9;
    #1;
    checks++; if (if3.q1_hit !== 1'b0 || if3.q1_data !== 32'h0) begin failures++; $display("FAIL fp_q1miss got=%0h/%0h exp=0/0", if3.q1_hit, if3.q1_data); end
    applyReset();
    drv3(1, 1, 5'd5, 32'hA, 32'h500);
    tick();
    drv3(1, 1, 5'd9, 32'h99, 32'h504);
    tick();
    drv3(0, 1, 5'd5, 32'hC, 32'h508);
    tick();
    drv3(0, 0, 0, 0, 0);
    if3.q0_addr = 5'd5;
    if3.q1_addr = 5'd9;
    #1;
    checks++; if (if3.q0_hit !== FWD || if3.q0_data !== (FWD ? 32'hA : 32'h0)) begin failures++; $display("FAIL fp_old_q0 got=%0h/%0h exp=%0h/%0h", if3.q0_hit, if3.q0_data, FWD, (FWD ? 32'hA : 32'h0)); end
    checks++; if (if3.q1_hit !== FWD || if3.q1_data !== (FWD ? 32'h99 : 32'h0)) begin failures++; $display("FAIL fp_mid_q1 got=%0h/%0h exp=%0h/%0h", if3.q1_hit, if3.q1_data, FWD, (FWD ? 32'h99 : 32'h0)); end
    checks++; if (if3.out_addr !== 5'd5 || if3.out_data !== 32'hA || if3.out_pc !== 32'h500) begin failures++; $display("FAIL fp_out2 got=%0h/%0h/%0h exp=5/a/500", if3.out_addr, if3.out_data, if3.out_pc); end
    tick();
    checks++; if (if3.q0_hit !== 1'b0 || if3.q0_data !== 32'h0) begin failures++; $display("FAIL fp_gone_q0 got=%0h/%0h exp=0/0", if3.q0_hit, if3.q0_data); end
    checks++; if (if3.out_addr !== 5'd9 || if3.out_data !== 32'h99 || if3.out_we !== 1'b1) begin failures++; $display("FAIL fp_out3 got=%0h/%0h/%0h exp=9/99/1", if3.out_addr, if3.out_data, if3.out_we); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idleAll();
    test_reset();
    test_latency();
    test_zero_suppress();
    test_stall_flush();
    test_reset_midstream();
    test_forward_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
